// File: rtl/fetch_pc_pkg.sv
// Shared encodings for the fetch PC generator: update kinds, FSM states and reset vector.
package fetch_pc_pkg;

  typedef enum logic [1:0] {
    UpdSeq  = 2'b00,
    UpdJalr = 2'b01,
    UpdJal  = 2'b10,
    UpdBr   = 2'b11
  } upd_kind_e;

  typedef enum logic [1:0] {
    StIssue = 2'b00,
    StWait  = 2'b01,
    StHalt  = 2'b10
  } state_e;

  localparam logic [31:0] DefaultResetVec = 32'h8000_0000;

endpackage

// File: rtl/fetch_pc_target.sv
// Next-PC target arithmetic and alignment check; purely combinational.
module fetch_pc_target
  import fetch_pc_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] i_pc,
  input  logic [1:0]      i_kind,
  input  logic            i_br_taken,
  input  logic [XLEN-1:0] i_rs1,
  input  logic [XLEN-1:0] i_imm,
  output logic [XLEN-1:0] o_target,
  output logic            o_misaligned
);

  logic [XLEN-1:0] w_seq;
  logic [XLEN-1:0] w_rel;
  logic [XLEN-1:0] w_ind;

  assign w_seq = i_pc + XLEN'(4);
  assign w_rel = i_pc + i_imm;
  assign w_ind = i_rs1 + i_imm;

  always_comb begin
    o_target = w_seq;
    case (upd_kind_e'(i_kind))
      UpdSeq:  o_target = w_seq;
      UpdJal:  o_target = w_rel;
      UpdJalr: o_target = {w_ind[XLEN-1:1], 1'b0};
      UpdBr:   o_target = i_br_taken ? w_rel : w_seq;
      default: o_target = w_seq;
    endcase
  end

  // Only bit 1 is checked: bit 0 is already cleared for JALR.
  assign o_misaligned = o_target[1];

endmodule

// File: rtl/fetch_pc_gen.sv
// Fetch PC generator: offers a PC to the IFU, then waits for the EXU's next-PC update.
// Optional performance counters are enabled with the PC_PERF_EN macro.
module fetch_pc_gen
  import fetch_pc_pkg::*;
#(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = XLEN'(DefaultResetVec)
) (
  input  logic            clk,
  input  logic            rst,
  output logic            o_pc_valid,
  input  logic            i_pc_ready,
  output logic [XLEN-1:0] o_pc,
  input  logic            i_upd_valid,
  input  logic [1:0]      i_upd_kind,
  input  logic            i_br_taken,
  input  logic [XLEN-1:0] i_rs1_data,
  input  logic [XLEN-1:0] i_imm_data,
  input  logic            i_trap_valid,
  input  logic [XLEN-1:0] i_trap_vec,
  input  logic            i_mret_valid,
  input  logic [XLEN-1:0] i_mepc,
  output logic            o_fault,
  output logic [XLEN-1:0] o_fault_addr
`ifdef PC_PERF_EN
  ,
  output logic [XLEN-1:0] o_perf_issue,
  output logic [XLEN-1:0] o_perf_taken
`endif
);

  state_e          r_state, w_state_d;
  logic [XLEN-1:0] r_pc, w_pc_d;
  logic            r_fault, w_fault_d;
  logic [XLEN-1:0] r_fault_addr, w_fault_addr_d;
  logic            w_hs;
  logic            w_upd_acc;
  logic [XLEN-1:0] w_target;
  logic            w_misaligned;

  fetch_pc_target #(
    .XLEN(XLEN)
  ) u_target (
    .i_pc        (r_pc),
    .i_kind      (i_upd_kind),
    .i_br_taken  (i_br_taken),
    .i_rs1       (i_rs1_data),
    .i_imm       (i_imm_data),
    .o_target    (w_target),
    .o_misaligned(w_misaligned)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= StIssue;
      r_pc         <= RESET_VEC;
      r_fault      <= 1'b0;
      r_fault_addr <= '0;
    end else begin
      r_state      <= w_state_d;
      r_pc         <= w_pc_d;
      r_fault      <= w_fault_d;
      r_fault_addr <= w_fault_addr_d;
    end
  end

  // Trap beats mret beats the normal flow; either redirect drops a same-cycle handshake.
  always_comb begin
    w_state_d      = r_state;
    w_pc_d         = r_pc;
    w_fault_d      = r_fault;
    w_fault_addr_d = r_fault_addr;
    w_hs           = 1'b0;
    w_upd_acc      = 1'b0;
    if (i_trap_valid) begin
      w_state_d = StIssue;
      w_pc_d    = {i_trap_vec[XLEN-1:2], 2'b00};
      w_fault_d = 1'b0;
    end else if (i_mret_valid && r_state != StHalt) begin
      w_state_d = StIssue;
      w_pc_d    = {i_mepc[XLEN-1:2], 2'b00};
    end else begin
      case (r_state)
        StIssue: begin
          if (i_pc_ready) begin
            w_hs      = 1'b1;
            w_state_d = StWait;
          end
        end
        StWait: begin
          if (i_upd_valid) begin
            w_upd_acc = 1'b1;
            if (w_misaligned) begin
              w_state_d      = StHalt;
              w_fault_d      = 1'b1;
              w_fault_addr_d = w_target;
            end else begin
              w_state_d = StIssue;
              w_pc_d    = w_target;
            end
          end
        end
        StHalt:  w_state_d = StHalt;
        default: w_state_d = StIssue;
      endcase
    end
  end

  always_comb begin
    o_pc_valid   = (r_state == StIssue);
    o_pc         = r_pc;
    o_fault      = r_fault;
    o_fault_addr = r_fault_addr;
  end

`ifdef PC_PERF_EN
  logic [XLEN-1:0] r_perf_issue;
  logic [XLEN-1:0] r_perf_taken;
  logic            w_taken;

  assign w_taken = w_upd_acc && (upd_kind_e'(i_upd_kind) != UpdSeq) &&
                   (w_target != r_pc + XLEN'(4));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_issue <= '0;
      r_perf_taken <= '0;
    end else begin
      if (w_hs && r_perf_issue != '1) r_perf_issue <= r_perf_issue + XLEN'(1);
      if (w_taken && r_perf_taken != '1) r_perf_taken <= r_perf_taken + XLEN'(1);
    end
  end

  assign o_perf_issue = r_perf_issue;
  assign o_perf_taken = r_perf_taken;
`else
  logic w_unused;
  assign w_unused = w_upd_acc ^ w_hs;
`endif

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Directed self-checking bench for fetch_pc_gen; perf checks run only with PC_PERF_EN.
module tb_fetch_pc_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        pc_valid;
  logic        pc_ready;
  logic [31:0] pc;
  logic        upd_valid;
  logic [1:0]  upd_kind;
  logic        br_taken;
  logic [31:0] rs1_data;
  logic [31:0] imm_data;
  logic        trap_valid;
  logic [31:0] trap_vec;
  logic        mret_valid;
  logic [31:0] mepc;
  logic        fault;
  logic [31:0] fault_addr;
`ifdef PC_PERF_EN
  logic [31:0] perf_issue;
  logic [31:0] perf_taken;
  logic [31:0] taken_base;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fetch_pc_gen dut (
    .clk         (clk),
    .rst         (rst),
    .o_pc_valid  (pc_valid),
    .i_pc_ready  (pc_ready),
    .o_pc        (pc),
    .i_upd_valid (upd_valid),
    .i_upd_kind  (upd_kind),
    .i_br_taken  (br_taken),
    .i_rs1_data  (rs1_data),
    .i_imm_data  (imm_data),
    .i_trap_valid(trap_valid),
    .i_trap_vec  (trap_vec),
    .i_mret_valid(mret_valid),
    .i_mepc      (mepc),
    .o_fault     (fault),
    .o_fault_addr(fault_addr)
`ifdef PC_PERF_EN
    ,
    .o_perf_issue(perf_issue),
    .o_perf_taken(perf_taken)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic handshake();
    pc_ready = 1'b1;
    tick();
    pc_ready = 1'b0;
  endtask

  task automatic update(input logic [1:0] kind, input logic tk, input logic [31:0] rs1,
                        input logic [31:0] imm);
    upd_valid = 1'b1;
    upd_kind  = kind;
    br_taken  = tk;
    rs1_data  = rs1;
    imm_data  = imm;
    tick();
    upd_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; pc_ready = 1'b0; upd_valid = 1'b0; upd_kind = 2'b00; br_taken = 1'b0;
    rs1_data = '0; imm_data = '0; trap_valid = 1'b0; trap_vec = '0; mret_valid = 1'b0;
    mepc = '0;
    tick();
    rst = 1'b0;
    check("rst_valid", {31'd0, pc_valid}, 32'd1);
    check("rst_pc", pc, 32'h8000_0000);
    check("rst_fault", {31'd0, fault}, 32'd0);
    check("rst_fault_addr", fault_addr, 32'd0);
`ifdef PC_PERF_EN
    check("rst_perf_issue", perf_issue, 32'd0);
    check("rst_perf_taken", perf_taken, 32'd0);
`endif

    // Stall, then update ignored while still in ISSUE
    tick(); tick();
    upd_valid = 1'b1; upd_kind = 2'b10; imm_data = 32'h40;
    tick();
    upd_valid = 1'b0;
    check("stall_pc", pc, 32'h8000_0000);
    check("stall_valid", {31'd0, pc_valid}, 32'd1);

    handshake();
    check("wait_valid", {31'd0, pc_valid}, 32'd0);
`ifdef PC_PERF_EN
    check("perf_issue_1", perf_issue, 32'd1);
`endif
    update(2'b00, 1'b0, '0, '0);
    check("seq_pc", pc, 32'h8000_0004);
    check("seq_valid", {31'd0, pc_valid}, 32'd1);

    handshake();
    update(2'b10, 1'b0, '0, 32'h0000_000C);
    check("jal_fwd", pc, 32'h8000_0010);
    handshake();
    update(2'b10, 1'b0, '0, 32'hFFFF_FFF0);
    check("jal_back", pc, 32'h8000_0000);
    handshake();
    update(2'b10, 1'b0, '0, 32'h0000_0010);
    check("jal_0x10", pc, 32'h8000_0010);

    handshake();
    update(2'b01, 1'b0, 32'h8000_0101, 32'h1);
    check("jalr_fault", {31'd0, fault}, 32'd1);
    check("jalr_fault_addr", fault_addr, 32'h8000_0102);
    check("jalr_pc_held", pc, 32'h8000_0010);
    check("halt_valid", {31'd0, pc_valid}, 32'd0);

    // mret and updates cannot leave HALT
    mret_valid = 1'b1; mepc = 32'h8000_0200; pc_ready = 1'b1;
    update(2'b00, 1'b0, '0, '0);
    mret_valid = 1'b0; pc_ready = 1'b0;
    check("halt_sticky_fault", {31'd0, fault}, 32'd1);
    check("halt_sticky_pc", pc, 32'h8000_0010);
    check("halt_sticky_valid", {31'd0, pc_valid}, 32'd0);

    trap_valid = 1'b1; trap_vec = 32'h8000_0022;
    tick();
    trap_valid = 1'b0;
    check("trap_pc", pc, 32'h8000_0020);
    check("trap_fault_clr", {31'd0, fault}, 32'd0);
    check("trap_valid", {31'd0, pc_valid}, 32'd1);

`ifdef PC_PERF_EN
    taken_base = perf_taken;
`endif
    handshake();
    update(2'b11, 1'b0, '0, 32'h8);
    check("br_not_taken", pc, 32'h8000_0024);
`ifdef PC_PERF_EN
    check("perf_taken_nt", perf_taken, taken_base);
`endif

    handshake();
    mret_valid = 1'b1; mepc = 32'h8000_0023;
    tick();
    mret_valid = 1'b0;
    check("mret_pc", pc, 32'h8000_0020);
    check("mret_valid", {31'd0, pc_valid}, 32'd1);
    handshake();
    update(2'b11, 1'b1, '0, 32'h8);
    check("br_taken", pc, 32'h8000_0028);
`ifdef PC_PERF_EN
    check("perf_taken_t", perf_taken, taken_base + 32'd1);
`endif

    // All three redirects at once: trap wins
    handshake();
    trap_valid = 1'b1; trap_vec = 32'h8000_1003;
    mret_valid = 1'b1; mepc = 32'h8000_2000;
    update(2'b10, 1'b0, '0, 32'h100);
    trap_valid = 1'b0; mret_valid = 1'b0;
    check("prio_pc", pc, 32'h8000_1000);
    check("prio_fault", {31'd0, fault}, 32'd0);
    check("prio_valid", {31'd0, pc_valid}, 32'd1);

    // mret aborts an ISSUE even with pc_ready high
    pc_ready = 1'b1; mret_valid = 1'b1; mepc = 32'hFFFF_FFFF;
    tick();
    pc_ready = 1'b0; mret_valid = 1'b0;
    check("abort_pc", pc, 32'hFFFF_FFFC);
    check("abort_valid", {31'd0, pc_valid}, 32'd1);

`ifdef PC_PERF_EN
    force dut.r_perf_issue = 32'hFFFF_FFFF;
    #1;
    release dut.r_perf_issue;
`endif
    handshake();
`ifdef PC_PERF_EN
    check("perf_issue_sat", perf_issue, 32'hFFFF_FFFF);
`endif
    update(2'b00, 1'b0, '0, '0);
    check("wrap_pc", pc, 32'h0000_0000);

    // Reset mid-WAIT discards a pending update
    handshake();
    rst = 1'b1;
    update(2'b10, 1'b0, '0, 32'h40);
    rst = 1'b0;
    check("midrst_pc", pc, 32'h8000_0000);
    check("midrst_valid", {31'd0, pc_valid}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
